// File: rtl/vga_pkg.sv
// Shared VGA timing constants, pixel types and RGB332 expansion for the scanout path.
package vga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    localparam int FB_W     = 320;
    localparam int FB_H     = 240;
    localparam int ADDR_W   = 17;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Bit replication keeps full-scale codes mapping to 0xFF.
    function automatic rgb888_t rgb332_to_rgb888(input logic [7:0] p);
        rgb888_t c;
        c.r = {p[7:5], p[7:5], p[7:6]};
        c.g = {p[4:2], p[4:2], p[4:3]};
        c.b = {4{p[1:0]}};
        return c;
    endfunction
endpackage

// File: rtl/vga_framebuffer_scanout_if.sv
// Synchronous-read framebuffer port between the scanout engine and video RAM.
interface vga_framebuffer_scanout_if #(parameter int ADDR_W = vga_pkg::ADDR_W);
    logic [ADDR_W-1:0] fb_addr;
    logic              fb_rd_en;
    logic [7:0]        fb_data;

    modport master (output fb_addr, output fb_rd_en, input fb_data);
    modport slave  (input fb_addr, input fb_rd_en, output fb_data);
endinterface

// File: rtl/vga_timing.sv
// Pixel-phase divider, h/v scan counters and sync/active/frame decode.
module vga_timing #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_TOTAL  = vga_pkg::H_TOTAL,
    parameter int HS_START = vga_pkg::HS_START,
    parameter int HS_END   = vga_pkg::HS_END,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_TOTAL  = vga_pkg::V_TOTAL,
    parameter int VS_START = vga_pkg::VS_START,
    parameter int VS_END   = vga_pkg::VS_END
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] hcnt,
    output logic [9:0] vcnt,
    output logic       active,
    output logic       hs_n,
    output logic       vs_n,
    output logic       frame_start
);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] HS_LO  = 10'(HS_START);
    localparam logic [9:0] HS_HI  = 10'(HS_END);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] VS_LO  = 10'(VS_START);
    localparam logic [9:0] VS_HI  = 10'(VS_END);

    logic ph;
    logic h_last, v_last;

    assign pix_en = ph;
    assign h_last = (hcnt == H_LAST);
    assign v_last = (vcnt == V_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            ph   <= 1'b0;
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            ph <= ~ph;
            if (ph) begin
                if (h_last) begin
                    hcnt <= '0;
                    vcnt <= v_last ? '0 : vcnt + 10'd1;
                end else begin
                    hcnt <= hcnt + 10'd1;
                end
            end
        end
    end

    assign active      = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign hs_n        = !((hcnt >= HS_LO) && (hcnt <= HS_HI));
    assign vs_n        = !((vcnt >= VS_LO) && (vcnt <= VS_HI));
    // Asserted during the clk whose closing edge wraps the scan to (0,0).
    assign frame_start = ph && h_last && v_last && !rst;
endmodule

// File: rtl/vga_framebuffer_scanout.sv
// 640x480 VGA scanout of a 320x240 RGB332 framebuffer with 2x pixel doubling.
module vga_framebuffer_scanout
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter int FB_W     = vga_pkg::FB_W,
    parameter int FB_H     = vga_pkg::FB_H,
    parameter int ADDR_W   = vga_pkg::ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    vga_framebuffer_scanout_if.master fb,
    output logic                      vgaclk,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      sync_b,
    output logic                      blank_b,
    output logic [7:0]                r,
    output logic [7:0]                g,
    output logic [7:0]                b,
    output logic                      frame_start
);
    logic       pix_en, active, hs_n, vs_n;
    logic [9:0] hcnt, vcnt;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_TOTAL  (H_ACTIVE + H_FP + H_SYNC + H_BP),
        .HS_START (H_ACTIVE + H_FP),
        .HS_END   (H_ACTIVE + H_FP + H_SYNC - 1),
        .V_ACTIVE (V_ACTIVE),
        .V_TOTAL  (V_ACTIVE + V_FP + V_SYNC + V_BP),
        .VS_START (V_ACTIVE + V_FP),
        .VS_END   (V_ACTIVE + V_FP + V_SYNC - 1)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .active      (active),
        .hs_n        (hs_n),
        .vs_n        (vs_n),
        .frame_start (frame_start)
    );

    logic [ADDR_W-1:0] h_half, v_half, lin_addr;
    logic              rd;

    // Counters hold for both clks of a pixel, so the address does too;
    // v*320 is built as v*256 + v*64.
    always_comb begin
        h_half      = ADDR_W'(hcnt >> 1);
        v_half      = ADDR_W'(vcnt >> 1);
        lin_addr    = (v_half << 8) + (v_half << 6) + h_half;
        rd          = active && !rst && (h_half < ADDR_W'(FB_W)) && (v_half < ADDR_W'(FB_H));
        fb.fb_addr  = rd ? lin_addr : '0;
        fb.fb_rd_en = rd;
    end

    rgb888_t px;

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            sync_b  <= 1'b1;
            blank_b <= 1'b0;
            px      <= '0;
        end else if (pix_en) begin
            hsync   <= hs_n;
            vsync   <= vs_n;
            sync_b  <= hs_n & vs_n;
            blank_b <= active;
            px      <= active ? rgb332_to_rgb888(fb.fb_data) : '0;
        end
    end

    assign vgaclk = pix_en;
    assign r      = px.r;
    assign g      = px.g;
    assign b      = px.b;
endmodule
